// File: rtl/exec_pkg.sv
// Shared constants for the execute/memory slice: word sizes and ALU opcode encodings.
package exec_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 256;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NOT   = 3'b101;
  localparam logic [2:0] ALU_PASSA = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

endpackage

// File: rtl/exec_shifter.sv
// Combinational 8-bit barrel shifter/rotator with carry-out and zero flag.
module exec_shifter
  import exec_pkg::*;
(
  input  logic [DATA_W-1:0] sh_data,
  input  logic [2:0]        sh_count,
  input  logic              sh_dir,
  input  logic              sh_ro_bar,
  output logic [DATA_W-1:0] sh_out,
  output logic              sh_c,
  output logic              sh_z
);

  logic [2*DATA_W-1:0] shl_w;
  logic [2*DATA_W-1:0] shr_w;
  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] ror_w;

  // Widened shifts keep the last bit shifted out one position beyond the result field.
  always_comb begin
    shl_w = {{DATA_W{1'b0}}, sh_data} << sh_count;
    shr_w = {sh_data, {DATA_W{1'b0}}} >> sh_count;
    rol_w = {sh_data, sh_data} << sh_count;
    ror_w = {sh_data, sh_data} >> sh_count;
    sh_out = sh_data;
    sh_c   = 1'b0;
    if (sh_ro_bar) begin
      if (!sh_dir) begin
        sh_out = shl_w[DATA_W-1:0];
        sh_c   = shl_w[DATA_W];
      end else begin
        sh_out = shr_w[2*DATA_W-1:DATA_W];
        sh_c   = shr_w[DATA_W-1];
      end
    end else begin
      if (!sh_dir) begin
        sh_out = rol_w[2*DATA_W-1:DATA_W];
        sh_c   = (sh_count != 3'd0) & rol_w[DATA_W];
      end else begin
        sh_out = ror_w[DATA_W-1:0];
        sh_c   = (sh_count != 3'd0) & ror_w[DATA_W-1];
      end
    end
    sh_z = (sh_out == '0);
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory unit: combinational ALU and shifter plus a 256x8 data memory with
// asynchronous read and a synchronous clear-all reset.
module exec_mem_unit #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic              alu_cin,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_co,
  output logic              alu_z,
  input  logic [DATA_W-1:0] sh_data,
  input  logic [2:0]        sh_count,
  input  logic              sh_dir,
  input  logic              sh_ro_bar,
  output logic [DATA_W-1:0] sh_out,
  output logic              sh_c,
  output logic              sh_z,
  input  logic              mem_we,
  input  logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata
);

  import exec_pkg::*;

  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Nine-bit arithmetic: bit DATA_W is carry for ADD and borrow for SUB.
  always_comb begin
    sum_w   = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, alu_cin};
    diff_w  = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_W{1'b0}}, alu_cin};
    alu_out = '0;
    alu_co  = 1'b0;
    case (alu_op)
      ALU_ADD:   {alu_co, alu_out} = sum_w;
      ALU_SUB:   {alu_co, alu_out} = diff_w;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_NOT:   alu_out = ~alu_a;
      ALU_PASSA: alu_out = alu_a;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
    alu_z = (alu_out == '0);
  end

  exec_shifter u_shifter (
    .sh_data   (sh_data),
    .sh_count  (sh_count),
    .sh_dir    (sh_dir),
    .sh_ro_bar (sh_ro_bar),
    .sh_out    (sh_out),
    .sh_c      (sh_c),
    .sh_z      (sh_z)
  );

  // Reset clears every word and takes priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_q[mem_addr];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: behavioural model plus directed literal vectors.
module tb_exec_mem_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_co, alu_z;
  logic [7:0] sh_data;
  logic [2:0] sh_count;
  logic       sh_dir, sh_ro_bar;
  logic [7:0] sh_out;
  logic       sh_c, sh_z;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic [7:0] mdl_mem [256];

  always #5 clk = ~clk;

  exec_mem_unit #(.DATA_W(8), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_co    (alu_co),
    .alu_z     (alu_z),
    .sh_data   (sh_data),
    .sh_count  (sh_count),
    .sh_dir    (sh_dir),
    .sh_ro_bar (sh_ro_bar),
    .sh_out    (sh_out),
    .sh_c      (sh_c),
    .sh_z      (sh_z),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU reference from integer arithmetic.
  task automatic alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, output logic [7:0] out, output logic co);
    int s;
    co = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(cin); out = 8'(s % 256); co = (s > 255); end
      3'd1: begin s = int'(a) - int'(b) - int'(cin); out = 8'((s + 256) % 256); co = (s < 0); end
      3'd2: out = a & b;
      3'd3: out = a | b;
      3'd4: out = a ^ b;
      3'd5: out = ~a;
      3'd6: out = a;
      default: out = b;
    endcase
  endtask

  // Shifter reference: one bit position per step.
  task automatic sh_model(input logic [7:0] d_in, input logic [2:0] n, input logic dir,
                          input logic ro_bar, output logic [7:0] d, output logic c);
    d = d_in;
    c = 1'b0;
    for (int k = 0; k < int'(n); k++) begin
      if (!dir) begin
        c = d[7];
        d = {d[6:0], ro_bar ? 1'b0 : d[7]};
      end else begin
        c = d[0];
        d = {ro_bar ? 1'b0 : d[0], d[7:1]};
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mdl_mem[k] = 8'h00;
    end else if (mem_we) begin
      mdl_mem[mem_addr] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_out;
    logic       e_c;
    if (check_en) begin
      alu_model(alu_op, alu_a, alu_b, alu_cin, e_out, e_c);
      check("mdl_alu_out", alu_out, e_out);
      check("mdl_alu_co", {7'd0, alu_co}, {7'd0, e_c});
      check("mdl_alu_z", {7'd0, alu_z}, {7'd0, e_out == 8'h00});
      sh_model(sh_data, sh_count, sh_dir, sh_ro_bar, e_out, e_c);
      check("mdl_sh_out", sh_out, e_out);
      check("mdl_sh_c", {7'd0, sh_c}, {7'd0, e_c});
      check("mdl_sh_z", {7'd0, sh_z}, {7'd0, e_out == 8'h00});
      check("mdl_mem_rdata", mem_rdata, mdl_mem[mem_addr]);
    end
  end

  task automatic alu_vec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] e_out, input logic e_co);
    @(posedge clk); #1;
    alu_op = op; alu_a = a; alu_b = b; alu_cin = cin;
    #1;
    check("lit_alu_out", alu_out, e_out);
    check("lit_alu_co", {7'd0, alu_co}, {7'd0, e_co});
    check("lit_alu_z", {7'd0, alu_z}, {7'd0, e_out == 8'h00});
  endtask

  task automatic sh_vec(input logic [7:0] d, input logic [2:0] n, input logic dir,
                        input logic ro_bar, input logic [7:0] e_out, input logic e_c);
    @(posedge clk); #1;
    sh_data = d; sh_count = n; sh_dir = dir; sh_ro_bar = ro_bar;
    #1;
    check("lit_sh_out", sh_out, e_out);
    check("lit_sh_c", {7'd0, sh_c}, {7'd0, e_c});
    check("lit_sh_z", {7'd0, sh_z}, {7'd0, e_out == 8'h00});
  endtask

  initial begin
    reset = 1'b1;
    alu_op = 3'd0; alu_a = 8'h00; alu_b = 8'h00; alu_cin = 1'b0;
    sh_data = 8'h00; sh_count = 3'd0; sh_dir = 1'b0; sh_ro_bar = 1'b1;
    mem_we = 1'b0; mem_addr = 8'h00; mem_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;

    // Memory reads zero everywhere after reset.
    mem_addr = 8'h00; #1; check("rst_mem_00", mem_rdata, 8'h00);
    mem_addr = 8'h10; #1; check("rst_mem_10", mem_rdata, 8'h00);
    mem_addr = 8'hFF; #1; check("rst_mem_ff", mem_rdata, 8'h00);

    // ALU directed vectors.
    alu_vec(3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    alu_vec(3'd0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
    alu_vec(3'd0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    alu_vec(3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1);
    alu_vec(3'd1, 8'h07, 8'h07, 1'b0, 8'h00, 1'b0);
    alu_vec(3'd1, 8'h07, 8'h07, 1'b1, 8'hFF, 1'b1);
    alu_vec(3'd1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0);
    alu_vec(3'd2, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0);
    alu_vec(3'd3, 8'hF0, 8'h0C, 1'b1, 8'hFC, 1'b0);
    alu_vec(3'd4, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
    alu_vec(3'd5, 8'h5A, 8'h00, 1'b1, 8'hA5, 1'b0);
    alu_vec(3'd6, 8'h81, 8'h42, 1'b1, 8'h81, 1'b0);
    alu_vec(3'd7, 8'h81, 8'h42, 1'b1, 8'h42, 1'b0);

    // Shifter directed vectors.
    sh_vec(8'h96, 3'd3, 1'b0, 1'b1, 8'hB0, 1'b0);
    sh_vec(8'h96, 3'd3, 1'b1, 1'b1, 8'h12, 1'b1);
    sh_vec(8'h96, 3'd3, 1'b0, 1'b0, 8'hB4, 1'b0);
    sh_vec(8'h96, 3'd3, 1'b1, 1'b0, 8'hD2, 1'b1);
    sh_vec(8'h80, 3'd1, 1'b0, 1'b1, 8'h00, 1'b1);
    sh_vec(8'h80, 3'd0, 1'b0, 1'b1, 8'h80, 1'b0);
    sh_vec(8'h01, 3'd0, 1'b1, 1'b0, 8'h01, 1'b0);
    sh_vec(8'h81, 3'd1, 1'b1, 1'b0, 8'hC0, 1'b1);
    sh_vec(8'h01, 3'd7, 1'b1, 1'b1, 8'h00, 1'b0);
    sh_vec(8'h81, 3'd7, 1'b0, 1'b0, 8'hC0, 1'b0);

    // Memory: write then read back.
    @(posedge clk); #1;
    mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'hA5;
    @(posedge clk); #1;
    mem_we = 1'b1; mem_addr = 8'h20; mem_wdata = 8'h5A;
    @(posedge clk); #1;
    mem_we = 1'b0; mem_addr = 8'h10;
    #1; check("mem_rd_10", mem_rdata, 8'hA5);
    mem_addr = 8'h20;
    #1; check("mem_rd_20", mem_rdata, 8'h5A);

    // Same-address write: old value until the edge, new value after.
    @(posedge clk); #1;
    mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'h3C;
    #1; check("mem_rw_old", mem_rdata, 8'hA5);
    @(posedge clk); #1;
    mem_we = 1'b0;
    #1; check("mem_rw_new", mem_rdata, 8'h3C);

    // Reset during a write: clear wins.
    @(posedge clk); #1;
    reset = 1'b1; mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'h77;
    @(posedge clk); #1;
    reset = 1'b0; mem_we = 1'b0;
    #1; check("mem_rst_wr_10", mem_rdata, 8'h00);
    mem_addr = 8'h20;
    #1; check("mem_rst_20", mem_rdata, 8'h00);

    // Pseudo-random sweep checked against the model every cycle.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      alu_op    = 3'($urandom_range(0, 7));
      alu_a     = 8'($urandom);
      alu_b     = 8'($urandom);
      alu_cin   = 1'($urandom);
      sh_data   = 8'($urandom);
      sh_count  = 3'($urandom);
      sh_dir    = 1'($urandom);
      sh_ro_bar = 1'($urandom);
      mem_we    = 1'($urandom);
      mem_addr  = 8'($urandom_range(0, 15));
      mem_wdata = 8'($urandom);
      reset     = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    #1;
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 Parameter: DATA_W, 8, operand/memory word width; fixed at 8, other values unsupported.
REQ-002 Parameter: MEM_DEPTH, 256, data-memory words, addressed by the full 8-bit address.
REQ-003 clk  in  1  single clock; all sequential logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 alu_op  in  3  ALU operation select.
REQ-006 alu_a, alu_b  in  8 each  ALU operands.
REQ-007 alu_cin  in  1  carry/borrow in; external logic already gates it with the carry-enable.
REQ-008 alu_out  out  8; alu_co  out  1; alu_z  out  1  ALU result, carry, zero.
REQ-009 sh_data  in  8; sh_count  in  3; sh_dir  in  1 (0=left, 1=right); sh_ro_bar  in  1 (1=shift, 0=rotate).
REQ-010 sh_out  out  8; sh_c  out  1; sh_z  out  1  shifter result, carry, zero.
REQ-011 mem_we  in  1; mem_addr  in  8; mem_wdata  in  8; mem_rdata  out  8  data-memory port.

Function
REQ-012 ALU and shifter SHALL be purely combinational, zero latency; outputs track inputs in the same cycle.
REQ-013 alu_op 000 ADD: {alu_co,alu_out} = alu_a + alu_b + alu_cin, 9-bit sum.
REQ-014 alu_op 001 SUB: alu_out = alu_a - alu_b - alu_cin mod 256; alu_co = 1 when a borrow occurs (alu_a < alu_b + alu_cin).
REQ-015 alu_op 010 AND, 011 OR, 100 XOR, 101 NOT alu_a, 110 pass alu_a, 111 pass alu_b; alu_co = 0 for all of these.
REQ-016 alu_z SHALL be 1 exactly when alu_out == 8'h00, for every op.
REQ-017 Shift (sh_ro_bar=1): logical, zero-fill; sh_c = last bit shifted out (bit 8-n for left, bit n-1 for right).
REQ-018 Rotate (sh_ro_bar=0): circular by sh_count; sh_c = the last bit that wrapped around (sh_out[0] for left, sh_out[7] for right).
REQ-019 sh_count = 0: sh_out = sh_data and sh_c = 0 in both modes.
REQ-020 sh_z SHALL be 1 exactly when sh_out == 8'h00.
REQ-021 Memory write: when mem_we=1 and reset=0 at a rising clk, mem[mem_addr] <= mem_wdata.
REQ-022 Memory read: asynchronous; mem_rdata = mem[mem_addr] combinationally at all times.
REQ-023 Read and write to the same address in one cycle: mem_rdata shows the old value until the edge, then the new value.

Reset
REQ-024 While reset=1 at a rising clk, every memory word SHALL be cleared to 8'h00, overriding mem_we.
REQ-025 ALU and shifter outputs SHALL NOT depend on reset.
REQ-026 After reset, mem_rdata SHALL be 8'h00 for every address until written.
REQ-027 Reset asserted mid-write: the clear wins and the write is discarded.

Structure
REQ-028 Shared package exec_pkg SHALL hold the ALU opcode constants (ALU_ADD .. ALU_PASSB), DATA_W and MEM_DEPTH.
REQ-029 Shifter SHALL be one sub-module, exec_shifter. The ALU and memory SHALL be inline in exec_mem_unit.

Verification
REQ-030 ADD a=8'hFF, b=8'h01, cin=0 -> out=8'h00, co=1, z=1; with cin=1 -> out=8'h01, co=1, z=0.
REQ-031 SUB a=8'h05, b=8'h07, cin=0 -> out=8'hFE, co=1, z=0; a=8'h07, b=8'h07 -> out=8'h00, co=0, z=1.
REQ-032 Shifter, data=8'b1001_0110, count=3:
- left shift -> sh_out=8'hB0, c=0.
- right shift -> 8'h12, c=1.
- left rotate -> 8'hB4, c=0.
- right rotate -> 8'hD2, c=1.
REQ-033 Shift data=8'h80, left shift, count=1 -> sh_out=8'h00, sh_c=1, sh_z=1; count=0 -> sh_out=8'h80, sh_c=0.
REQ-034 Memory sequence:
- write 8'hA5 to address 8'h10; read 8'h10 -> 8'hA5.
- assert reset with mem_we=1 to address 8'h10 -> address 8'h10 reads 8'h00 after the edge.
